// File: rtl/lc4_pipe_reg_chain_pkg.sv
// ---------------------------------------------------------------------------
// lc4_pipe_pkg
// Shared definitions for the LC4 inter-stage register chain.
//   - LC4_NOP            : instruction value carried by a bubble
//   - ctrl bit indices   : positions of the decoded control flags in ctrl
//   - lc4_word_t         : {valid, pc, insn, ctrl, data} at the default widths
//   - lc4_bubble()       : bubble word at the default widths
//   - lc4_bubble_flat()  : bubble image for arbitrary field widths, packed
//                          MSB..LSB as {valid, pc, insn, ctrl, data}
// ---------------------------------------------------------------------------
package lc4_pipe_pkg;

   localparam logic [15:0] LC4_NOP = 16'h0000;

   localparam int unsigned LC4_PC_W   = 16;
   localparam int unsigned LC4_INSN_W = 16;
   localparam int unsigned LC4_CTRL_W = 12;
   localparam int unsigned LC4_DATA_W = 64;

   // Bit positions inside the ctrl field. Bits above R2RE carry the
   // multi-bit select fields and have no individual names.
   localparam int unsigned REGFILE_WE = 0;
   localparam int unsigned NZP_WE     = 1;
   localparam int unsigned IS_LOAD    = 2;
   localparam int unsigned IS_STORE   = 3;
   localparam int unsigned IS_BRANCH  = 4;
   localparam int unsigned IS_CTRL    = 5;
   localparam int unsigned SEL_PC1    = 6;
   localparam int unsigned R1RE       = 7;
   localparam int unsigned R2RE       = 8;

   // Upper bound on the flattened word width handled by lc4_bubble_flat.
   localparam int unsigned LC4_MAX_W = 256;

   typedef struct packed {
      logic                  valid;
      logic [LC4_PC_W-1:0]   pc;
      logic [LC4_INSN_W-1:0] insn;
      logic [LC4_CTRL_W-1:0] ctrl;
      logic [LC4_DATA_W-1:0] data;
   } lc4_word_t;

   function automatic lc4_word_t lc4_bubble();
      lc4_word_t w;
      w       = '0;
      w.insn  = LC4_NOP;
      return w;
   endfunction

   // Only the insn field of a bubble is non-zero, so the image is simply the
   // NOP value shifted above the ctrl and data fields. The caller zero-extends
   // the NOP to 64 bits and keeps the low bits that fit its own word.
   function automatic logic [LC4_MAX_W-1:0] lc4_bubble_flat(
      input int unsigned ctrl_w,
      input int unsigned data_w,
      input logic [63:0] nop
   );
      logic [LC4_MAX_W-1:0] v;
      v        = '0;
      v[63:0]  = nop;
      return v << (ctrl_w + data_w);
   endfunction

endpackage

// File: rtl/lc4_pipe_slice.sv
// ---------------------------------------------------------------------------
// lc4_pipe_slice
// One register slice of the pipeline chain. Holds a flattened word and
// supports load / hold / kill. Kill (bubble) has priority over load.
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-low reset (loads BUBBLE)
//   i_load  capture i_d
//   i_kill  replace contents with BUBBLE
//   i_d     incoming word
//   o_q     registered word
// ---------------------------------------------------------------------------
module lc4_pipe_slice #(
   parameter int unsigned  W      = 8,
   parameter logic [W-1:0] BUBBLE = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic         i_kill,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_q <= BUBBLE;
      end else if (i_kill) begin
         r_q <= BUBBLE;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/lc4_pipe_reg_chain.sv
// ---------------------------------------------------------------------------
// lc4_pipe_reg_chain
// Parametrised LC4 inter-stage register: DEPTH cascaded slices carrying
// {valid, pc, insn, ctrl, data}, with global write enable, stall (hold all),
// flush (bubble all, drop incoming word) and saturating stall/flush counters.
// Edge priority with rst high: gwe==0 > flush > stall > advance.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   gwe               global write enable; low freezes everything
//   stall, flush      hold / kill the chain
//   clr_cnt           clear both performance counters
//   in_*              incoming word (in_valid==0 loads a bubble)
//   out_*             last slice contents, straight from registers
//   stall_cnt         cycles with stall & ~flush
//   flush_cnt         cycles with flush
// ---------------------------------------------------------------------------
module lc4_pipe_reg_chain
   import lc4_pipe_pkg::*;
#(
   parameter int unsigned       DEPTH    = 1,
   parameter int unsigned       PC_W     = 16,
   parameter int unsigned       INSN_W   = 16,
   parameter int unsigned       CTRL_W   = 12,
   parameter int unsigned       DATA_W   = 64,
   parameter logic [INSN_W-1:0] NOP_INSN = INSN_W'(LC4_NOP),
   parameter int unsigned       CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              gwe,
   input  logic              stall,
   input  logic              flush,
   input  logic              clr_cnt,
   input  logic              in_valid,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [INSN_W-1:0] in_insn,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [PC_W-1:0]   out_pc,
   output logic [INSN_W-1:0] out_insn,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam int unsigned W        = 1 + PC_W + INSN_W + CTRL_W + DATA_W;
   localparam int unsigned OFS_CTRL = DATA_W;
   localparam int unsigned OFS_INSN = DATA_W + CTRL_W;
   localparam int unsigned OFS_PC   = DATA_W + CTRL_W + INSN_W;

   localparam logic [LC4_MAX_W-1:0] BUBBLE_FULL =
      lc4_bubble_flat(CTRL_W, DATA_W, 64'(NOP_INSN));
   localparam logic [W-1:0] BUBBLE = BUBBLE_FULL[W-1:0];

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // -----------------------------------------------------------------------
   // Slice controls shared by every slice: the chain moves as one unit.
   // -----------------------------------------------------------------------
   logic w_load;
   logic w_kill;

   assign w_kill = gwe & flush;
   assign w_load = gwe & ~flush & ~stall;

   // An invalid incoming word is normalised to a bubble so that stray
   // ctrl bits (write enables) never enter the chain.
   logic [W-1:0] w_in_word;

   assign w_in_word = in_valid ? {1'b1, in_pc, in_insn, in_ctrl, in_data} : BUBBLE;

   logic [W-1:0] w_q [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_slice
      logic [W-1:0] w_d;

      if (k == 0) begin : g_head
         assign w_d = w_in_word;
      end else begin : g_body
         assign w_d = w_q[k-1];
      end

      lc4_pipe_slice #(
         .W      (W),
         .BUBBLE (BUBBLE)
      ) u_slice (
         .clk    (clk),
         .rst    (rst),
         .i_load (w_load),
         .i_kill (w_kill),
         .i_d    (w_d),
         .o_q    (w_q[k])
      );
   end

   logic [W-1:0] w_last;

   assign w_last    = w_q[DEPTH-1];
   assign out_valid = w_last[W-1];
   assign out_pc    = w_last[OFS_PC   +: PC_W];
   assign out_insn  = w_last[OFS_INSN +: INSN_W];
   assign out_ctrl  = w_last[OFS_CTRL +: CTRL_W];
   assign out_data  = w_last[0        +: DATA_W];

   // -----------------------------------------------------------------------
   // Performance counters: clear beats increment, both saturate.
   // -----------------------------------------------------------------------
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic [CNT_W-1:0] w_stall_nxt;
   logic [CNT_W-1:0] w_flush_nxt;

   always_comb begin
      w_stall_nxt = r_stall_cnt;
      w_flush_nxt = r_flush_cnt;
      if (clr_cnt) begin
         w_stall_nxt = '0;
         w_flush_nxt = '0;
      end else begin
         if (stall && !flush && (r_stall_cnt != CNT_MAX)) begin
            w_stall_nxt = r_stall_cnt + CNT_ONE;
         end
         if (flush && (r_flush_cnt != CNT_MAX)) begin
            w_flush_nxt = r_flush_cnt + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (gwe) begin
         r_stall_cnt <= w_stall_nxt;
         r_flush_cnt <= w_flush_nxt;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_lc4_pipe_reg_chain.sv
module tb_lc4_pipe_reg_chain;

   logic        clk = 1'b0;
   logic        rst, gwe, stall, flush, clr_cnt, in_valid;
   logic [15:0] in_pc, in_insn;
   logic [11:0] in_ctrl;
   logic [63:0] in_data;

   logic        o2_valid, o1_valid;
   logic [15:0] o2_pc, o2_insn, o1_pc, o1_insn;
   logic [11:0] o2_ctrl, o1_ctrl;
   logic [63:0] o2_data, o1_data;
   logic [3:0]  o2_scnt, o2_fcnt, o1_scnt, o1_fcnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lc4_pipe_reg_chain #(.DEPTH(2), .CNT_W(4)) u_dut2 (
      .clk(clk), .rst(rst), .gwe(gwe), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
      .in_valid(in_valid), .in_pc(in_pc), .in_insn(in_insn), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(o2_valid), .out_pc(o2_pc), .out_insn(o2_insn), .out_ctrl(o2_ctrl), .out_data(o2_data),
      .stall_cnt(o2_scnt), .flush_cnt(o2_fcnt)
   );

   lc4_pipe_reg_chain #(.DEPTH(1), .CNT_W(4)) u_dut1 (
      .clk(clk), .rst(rst), .gwe(gwe), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
      .in_valid(in_valid), .in_pc(in_pc), .in_insn(in_insn), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(o1_valid), .out_pc(o1_pc), .out_insn(o1_insn), .out_ctrl(o1_ctrl), .out_data(o1_data),
      .stall_cnt(o1_scnt), .flush_cnt(o1_fcnt)
   );

   // Reference model: a pipeline is a list of words; advancing pushes the new
   // word at the front and the oldest one falls off the end.
   typedef struct {
      bit        v;
      bit [15:0] pc;
      bit [15:0] insn;
      bit [11:0] ctrl;
      bit [63:0] data;
   } word_t;

   word_t m2 [2];
   word_t m1 [1];
   int    m_sc = 0;
   int    m_fc = 0;

   function automatic word_t bubble();
      word_t b;
      b.v = 1'b0; b.pc = '0; b.insn = 16'h0000; b.ctrl = '0; b.data = '0;
      return b;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      word_t inw;
      if (!rst) begin
         m2[0] = bubble(); m2[1] = bubble(); m1[0] = bubble();
         m_sc = 0; m_fc = 0;
      end else if (gwe) begin
         if (clr_cnt) begin
            m_sc = 0; m_fc = 0;
         end else if (flush) begin
            m_fc = (m_fc < 15) ? m_fc + 1 : 15;
         end else if (stall) begin
            m_sc = (m_sc < 15) ? m_sc + 1 : 15;
         end
         if (flush) begin
            m2[0] = bubble(); m2[1] = bubble(); m1[0] = bubble();
         end else if (!stall) begin
            if (in_valid) begin
               inw.v = 1'b1; inw.pc = in_pc; inw.insn = in_insn;
               inw.ctrl = in_ctrl; inw.data = in_data;
            end else begin
               inw = bubble();
            end
            m2[1] = m2[0];
            m2[0] = inw;
            m1[0] = inw;
         end
      end
   endtask

   task automatic check_all();
      chk("d2_valid", 64'(o2_valid), 64'(m2[1].v));
      chk("d2_pc",    64'(o2_pc),    64'(m2[1].pc));
      chk("d2_insn",  64'(o2_insn),  64'(m2[1].insn));
      chk("d2_ctrl",  64'(o2_ctrl),  64'(m2[1].ctrl));
      chk("d2_data",  o2_data,       m2[1].data);
      chk("d2_scnt",  64'(o2_scnt),  64'(m_sc));
      chk("d2_fcnt",  64'(o2_fcnt),  64'(m_fc));
      chk("d1_valid", 64'(o1_valid), 64'(m1[0].v));
      chk("d1_pc",    64'(o1_pc),    64'(m1[0].pc));
      chk("d1_insn",  64'(o1_insn),  64'(m1[0].insn));
      chk("d1_ctrl",  64'(o1_ctrl),  64'(m1[0].ctrl));
      chk("d1_data",  o1_data,       m1[0].data);
      chk("d1_scnt",  64'(o1_scnt),  64'(m_sc));
      chk("d1_fcnt",  64'(o1_fcnt),  64'(m_fc));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic rand_word(input logic v);
      in_valid = v;
      in_pc    = 16'($urandom);
      in_insn  = 16'($urandom);
      in_ctrl  = 12'($urandom);
      in_data  = {$urandom, $urandom};
   endtask

   task automatic ctl(input logic r, input logic g, input logic s, input logic f, input logic c);
      rst = r; gwe = g; stall = s; flush = f; clr_cnt = c;
   endtask

   initial begin
      // Reset with a live-looking word on the inputs.
      ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      rand_word(1'b1);
      in_insn = 16'h1234;
      tick();
      tick();
      chk("rst_valid", 64'(o2_valid), 64'd0);
      chk("rst_insn",  64'(o2_insn),  64'h0000);
      chk("rst_ctrl",  64'(o2_ctrl),  64'd0);
      chk("rst_scnt",  64'(o2_scnt),  64'd0);
      chk("rst_fcnt",  64'(o2_fcnt),  64'd0);

      // Streaming pc 1..4.
      ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         rand_word(1'b1);
         in_pc = 16'(i);
         tick();
      end
      chk("stream_pc2", 64'(o2_pc), 64'd3);
      chk("stream_pc1", 64'(o1_pc), 64'd4);
      chk("stream_v",   64'(o2_valid), 64'd1);

      // Stall three cycles mid-stream with new words offered.
      for (int i = 0; i < 3; i++) begin
         stall = 1'b1;
         rand_word(1'b1);
         tick();
         chk("stall_hold_pc", 64'(o2_pc), 64'd3);
      end
      stall = 1'b0;
      chk("stall_cnt3", 64'(o2_scnt), 64'd3);
      rand_word(1'b1);
      tick();
      chk("stall_resume_pc", 64'(o2_pc), 64'd4);
      rand_word(1'b0);
      tick();
      rand_word(1'b1);
      tick();

      // Flush together with stall on a full chain.
      stall = 1'b1; flush = 1'b1;
      rand_word(1'b1);
      tick();
      chk("flush_valid", 64'(o2_valid), 64'd0);
      chk("flush_ctrl",  64'(o2_ctrl),  64'd0);
      chk("flush_fcnt",  64'(o2_fcnt),  64'd1);
      chk("flush_scnt",  64'(o2_scnt),  64'd3);
      ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      rand_word(1'b1); tick();
      rand_word(1'b1); tick();

      // Global write enable low: nothing moves, clr ignored.
      for (int i = 0; i < 4; i++) begin
         ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
         rand_word(1'b1);
         tick();
      end
      chk("gwe_scnt", 64'(o2_scnt), 64'd3);
      chk("gwe_fcnt", 64'(o2_fcnt), 64'd1);

      // Reset with gwe low still resets.
      ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      chk("rst_gwe0_valid", 64'(o2_valid), 64'd0);
      chk("rst_gwe0_scnt",  64'(o2_scnt),  64'd0);

      // Randomised traffic.
      for (int i = 0; i < 300; i++) begin
         ctl(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) != 0),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 29) == 0));
         rand_word(($urandom_range(0, 3) != 0));
         tick();
      end

      // Counter saturation, then clear overriding a stall.
      ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      chk("sat_clr0", 64'(o2_scnt), 64'd0);
      for (int i = 0; i < 20; i++) begin
         ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
         rand_word(1'b1);
         tick();
      end
      chk("sat_scnt15", 64'(o2_scnt), 64'd15);
      chk("sat_d1_15",  64'(o1_scnt), 64'd15);
      ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      chk("sat_clr_stall", 64'(o2_scnt), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lc4_pipe_reg_chain.md
Name: lc4_pipe_reg_chain

Overview:
- Parametrised successor to the fixed-field LC4 inter-stage register.
- Carries a generic {valid, pc, insn, ctrl, data} word through DEPTH cascaded slices.
- Adds native stall (hold), flush (bubble injection) and global write-enable gating.
- Includes saturating stall/flush event counters for pipeline performance debug; sits between any two LC4 pipeline stages (F/D, D/X, X/M, M/W).

Parameters:
- DEPTH, 1, number of cascaded register slices (1..4); latency in cycles.
- PC_W, 16, program-counter field width.
- INSN_W, 16, instruction field width.
- CTRL_W, 12, decoded control bits (sel/re/we/is_* flags).
- DATA_W, 64, opaque datapath payload (rs/rt/wdata/alu/lmd concatenation).
- NOP_INSN, 16'h0000, instruction value written into a bubble.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- gwe  in  1  global write enable; 0 freezes all state, including counters.
- stall  in  1  hold all slices.
- flush  in  1  kill all slices and the incoming word.
- clr_cnt  in  1  synchronous clear of both counters.
- in_valid  in  1  incoming word is a real instruction.
- in_pc  in  PC_W  incoming pc_plus_one.
- in_insn  in  INSN_W  incoming instruction.
- in_ctrl  in  CTRL_W  incoming control bits.
- in_data  in  DATA_W  incoming payload.
- out_valid / out_pc / out_insn / out_ctrl / out_data  out  1 / PC_W / INSN_W / CTRL_W / DATA_W  last slice contents.
- stall_cnt  out  CNT_W  stalled cycles.
- flush_cnt  out  CNT_W  flush events.

Behaviour:
- Reset (rst==0 at a clk edge, independent of gwe):
  - every slice holds a bubble: valid=0, pc=0, insn=NOP_INSN, ctrl=0, data=0.
  - stall_cnt=0, flush_cnt=0.
- Bubble definition: valid=0, insn=NOP_INSN, ctrl=0, pc=0, data=0. Bubbles never carry write enables.
- Per edge with rst==1, priority order: gwe==0 > flush > stall > advance.
  - gwe==0: no state changes, counters hold, clr_cnt is ignored.
  - flush==1: all DEPTH slices become bubbles; the incoming word is discarded. Flush wins over a simultaneous stall.
  - stall==1 (flush==0): all slices hold their values.
  - advance: slice[0] loads the incoming word; slice[k] loads slice[k-1]. If in_valid==0, slice[0] loads a bubble regardless of the other in_* values.
- Latency: a word presented at edge t appears on out_* after edge t+DEPTH-1, i.e. DEPTH edges total, plus one edge per stalled cycle.
- Outputs are driven directly from the last slice's registers; no combinational path from in_* to out_*.
- Counters (gwe==1, rst==1):
  - clr_cnt==1: both counters go to 0. This has priority over increment in the same cycle.
  - stall_cnt: +1 on each cycle with stall & ~flush.
  - flush_cnt: +1 on each cycle with flush.
  - Both saturate at 2^CNT_W-1; no wrap.
- Reset asserted mid-stall or mid-flush: reset wins. The chain holds bubbles from the next edge onward.
- DEPTH==1 degenerates to a single LC4-style pipeline register with stall/flush.

Decomposition:
- Package lc4_pipe_pkg:
  - NOP constant.
  - ctrl bit-index localparams (REGFILE_WE, NZP_WE, IS_LOAD, IS_STORE, IS_BRANCH, IS_CTRL, SEL_PC1, R1RE, R2RE).
  - packed struct template for {valid, pc, insn, ctrl, data}.
  - bubble-builder function.
- Sub-module lc4_pipe_slice: one register with load/hold/kill controls, instantiated DEPTH times via generate.
- Counters live in the top-level module.

Test Plan:
- Reset: drive rst=0 for 2 cycles with in_valid=1, in_insn=16'h1234 -> out_valid=0, out_insn=16'h0000, out_ctrl=0, both counters 0.
- Streaming, DEPTH=2: present pc=16'h0001..0004, in_valid=1 on consecutive cycles -> same sequence on out_pc exactly 2 edges later, in order, out_valid=1.
- Stall: insert stall=1 for 3 cycles mid-stream -> out_* frozen for 3 cycles, no word lost or duplicated, stall_cnt=3.
- Flush with stall: flush=1 and stall=1 together while chain is full -> next edge all slices are bubbles (out_valid=0, out_ctrl=0), flush_cnt=1, stall_cnt unchanged.
- gwe gating: gwe=0 for 4 cycles with new inputs, stall=1 and clr_cnt=1 -> outputs and counters unchanged; rst=0 with gwe=0 still resets.
- Saturation, CNT_W=4: 20 stall cycles -> stall_cnt=15 and holds there; then clr_cnt=1 with stall=1 -> stall_cnt=0 on that edge.
